// File: rtl/col_pkg.sv
// Shared types for the colour event path: colour codes, qualifier states, event layout.
// With COL_EVT_TIMESTAMP_EN defined, events also carry a 16-bit millisecond timestamp.
package col_pkg;

  typedef enum logic [1:0] {
    COL_NONE = 2'b00,
    COL_R    = 2'b01,
    COL_G    = 2'b10,
    COL_B    = 2'b11
  } col_t;

  typedef enum logic {
    QUALIFY = 1'b0,
    HOLD    = 1'b1
  } qstate_t;

  localparam int DROP_MAX  = 255;
  localparam int CNT_W     = 24;
  localparam int TS_W      = 16;
  localparam int EVT_SEQ_W = 4;

  // Event layout at the default sequence width; the top re-declares it at its SEQ_W.
  typedef struct packed {
    col_t                 colour;
    logic [EVT_SEQ_W-1:0] seq;
`ifdef COL_EVT_TIMESTAMP_EN
    logic [TS_W-1:0]      ts;
`endif
  } col_evt_t;

  // {red, green, blue}: exactly one flag high names a colour, anything else is ambiguous.
  function automatic col_t col_decode(input logic [2:0] rgb);
    case (rgb)
      3'b100:  return COL_R;
      3'b010:  return COL_G;
      3'b001:  return COL_B;
      default: return COL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/col_evt_fifo.sv
// First-word-fall-through FIFO; head is visible on dout whenever empty is low.
// A push into a full FIFO is refused unless a pop happens on the same edge.
module col_evt_fifo #(
  parameter  int W     = 6,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  // Stale storage is masked so an empty FIFO presents all-zero head fields.
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/col_evt_qualifier.sv
// Synchronises the classifier LED flags, requires a colour to hold STABLE_CYCLES before
// accepting it, and queues one event per newly accepted colour. Macro: COL_EVT_TIMESTAMP_EN.
module col_evt_qualifier
  import col_pkg::*;
#(
  parameter int STABLE_CYCLES = 2500000,
  parameter int FIFO_DEPTH    = 4,
  parameter int SEQ_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             red_led,
  input  logic             green_led,
  input  logic             blue_led,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_colour,
  output logic [SEQ_W-1:0] evt_seq,
`ifdef COL_EVT_TIMESTAMP_EN
  output logic [TS_W-1:0]  evt_ts,
`endif
  output logic [1:0]       cur_colour,
  output logic [7:0]       drop_cnt
);

  typedef struct packed {
    col_t             colour;
    logic [SEQ_W-1:0] seq;
`ifdef COL_EVT_TIMESTAMP_EN
    logic [TS_W-1:0]  ts;
`endif
  } evt_t;

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);
  localparam int               EVT_W  = $bits(evt_t);

  logic [2:0]       sync1, sync2;
  col_t             dec, cand, cand_nxt, cur;
  qstate_t          state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept, push, pop, full, empty;
  logic [SEQ_W-1:0] seq;
  logic [7:0]       drop;
  evt_t             evt_in, evt_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {red_led, green_led, blue_led};
      sync2 <= sync1;
    end
  end

  assign dec = col_decode(sync2);

  always_comb begin
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    if (dec != cand) begin
      cand_nxt = dec;
      cnt_nxt  = CNT_W'(1);
    end else if (cnt < STABLE) begin
      cnt_nxt = cnt + 1'b1;
    end
    // HOLD is entered on the same edge the count reaches STABLE, so acceptance is one edge later.
    state_nxt = (cnt_nxt == STABLE) ? HOLD : QUALIFY;
    accept    = (state == HOLD) && (dec == cand) && (cand != cur);
    push      = accept && (cand != COL_NONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= QUALIFY;
      cand  <= COL_NONE;
      cnt   <= '0;
      cur   <= COL_NONE;
      seq   <= '0;
      drop  <= '0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
      if (accept) cur <= cand;
      // Sequence advances even for dropped events so the consumer can see the gap.
      if (push) seq <= seq + 1'b1;
      if (push && full && !pop && drop != 8'(DROP_MAX)) drop <= drop + 8'd1;
    end
  end

`ifdef COL_EVT_TIMESTAMP_EN
  localparam int CLK_HZ = 50000000;
  localparam int MS_DIV = CLK_HZ / 1000;
  localparam int PRE_W  = $clog2(MS_DIV);

  logic [PRE_W-1:0] pre;
  logic [TS_W-1:0]  ms;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      ms  <= '0;
    end else if (pre == PRE_W'(MS_DIV - 1)) begin
      pre <= '0;
      ms  <= ms + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign evt_in = '{colour: cand, seq: seq, ts: ms};
  assign evt_ts = evt_head.ts;
`else
  assign evt_in = '{colour: cand, seq: seq};
`endif

  col_evt_fifo #(
    .W     (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (evt_in),
    .pop   (pop),
    .dout  (evt_head),
    .full  (full),
    .empty (empty)
  );

  assign evt_valid  = !empty;
  assign pop        = evt_valid && evt_ready;
  assign evt_colour = evt_head.colour;
  assign evt_seq    = evt_head.seq;
  assign cur_colour = cur;
  assign drop_cnt   = drop;

endmodule

// File: tb/tb_col_evt_qualifier.sv
// Scoreboard bench: a run-length reference model predicts events, a monitor checks the FIFO head.
module tb_col_evt_qualifier;

  localparam int S  = 4;
  localparam int D  = 4;
  localparam int SW = 4;

  logic          clk = 0, rst_n = 0;
  logic          red_led = 0, green_led = 0, blue_led = 0, evt_ready = 0;
  logic          evt_valid;
  logic [1:0]    evt_colour, cur_colour;
  logic [SW-1:0] evt_seq;
  logic [7:0]    drop_cnt;
`ifdef COL_EVT_TIMESTAMP_EN
  logic [15:0]   evt_ts;
`endif

  int checks = 0, errors = 0, cyc = 0, pops = 0;

  always #5 clk = ~clk;

  col_evt_qualifier #(.STABLE_CYCLES(S), .FIFO_DEPTH(D), .SEQ_W(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .red_led    (red_led),
    .green_led  (green_led),
    .blue_led   (blue_led),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_colour (evt_colour),
    .evt_seq    (evt_seq),
`ifdef COL_EVT_TIMESTAMP_EN
    .evt_ts     (evt_ts),
`endif
    .cur_colour (cur_colour),
    .drop_cnt   (drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dec3(input logic r, input logic g, input logic b);
    case ({r, g, b})
      3'b100:  return 1;
      3'b010:  return 2;
      3'b001:  return 3;
      default: return 0;
    endcase
  endfunction

  // Reference model: a decoded colour (seen two edges late through the synchroniser)
  // is accepted once it has been present on S+1 consecutive edges.
  typedef struct { int colour; int seq; } ev_t;
  ev_t scb_q[$];
  int  pipe0 = 0, pipe1 = 0, run_val = 0, run_len = 0;
  int  m_cur = 0, m_seq = 0, m_drop = 0, occ = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe0 = 0; pipe1 = 0; run_val = 0; run_len = 0;
      m_cur = 0; m_seq = 0; m_drop = 0; occ = 0;
      scb_q.delete();
    end else begin
      int d;
      d     = pipe0;
      pipe0 = pipe1;
      pipe1 = dec3(red_led, green_led, blue_led);
      if (d == run_val) begin
        if (run_len < 1000) run_len++;
      end else begin
        run_val = d;
        run_len = 1;
      end
      if (occ > 0 && evt_ready) occ--;
      if (run_len >= S + 1 && d != m_cur) begin
        m_cur = d;
        if (d != 0) begin
          if (occ < D) begin
            occ++;
            scb_q.push_back('{d, m_seq});
          end else if (m_drop < 255) begin
            m_drop++;
          end
          m_seq = (m_seq + 1) % (1 << SW);
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc = 0;
    else        cyc++;
  end

  // Monitor: sample mid-cycle, after stimulus for the next edge has settled.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      chk("valid", evt_valid, occ > 0);
      if (evt_valid) begin
        if (scb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL head: unexpected event colour %0d seq %0d", evt_colour, evt_seq);
        end else begin
          chk("head colour", evt_colour, scb_q[0].colour);
          chk("head seq", evt_seq, scb_q[0].seq);
          if (evt_ready) begin
            void'(scb_q.pop_front());
            pops++;
          end
        end
      end
      chk("cur_colour", cur_colour, m_cur);
      chk("drop_cnt", drop_cnt, m_drop);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < n) chk("wait_cyc timeout", cyc, n);
  endtask

  task automatic leds(input logic r, input logic g, input logic b);
    red_led = r; green_led = g; blue_led = b;
  endtask

  initial begin
    int n, p0, g;
    logic [2:0] rgb;
    int len, pr;

    tick(3);
    chk("rst evt_valid", evt_valid, 0);
    chk("rst evt_colour", evt_colour, 0);
    chk("rst evt_seq", evt_seq, 0);
    chk("rst cur_colour", cur_colour, 0);
    chk("rst drop_cnt", drop_cnt, 0);
    rst_n = 1;
    evt_ready = 1;

    // First event latency: input before edge 10, event visible after edge 16 for one cycle.
    wait_cyc(9);  leds(1, 0, 0);
    wait_cyc(15); chk("lat e15 valid", evt_valid, 0);
    wait_cyc(16); chk("lat e16 valid", evt_valid, 1);
    chk("lat e16 colour", evt_colour, 1);
    chk("lat e16 seq", evt_seq, 0);
    wait_cyc(17); chk("lat e17 valid", evt_valid, 0);
    chk("lat e17 cur", cur_colour, 1);

    // Short green glitch is filtered; a sustained ambiguous reading settles on NONE.
    green_led = 1; tick(3); green_led = 0; tick(10);
    chk("glitch cur", cur_colour, 1);
    leds(1, 0, 1); tick(20);
    chk("ambig cur", cur_colour, 0);
    chk("ambig pops", pops, 1);

    // R, NONE, R: the reappearing red produces a fresh event.
    leds(1, 0, 0); tick(10);
    leds(0, 0, 0); tick(10);
    leds(1, 0, 0); tick(15);
    chk("rnr pops", pops, 3);
    chk("rnr cur", cur_colour, 1);

    // Six alternating colours with consumer stalled: four queued, two dropped.
    evt_ready = 0;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) leds(0, 1, 0); else leds(1, 0, 0);
      tick(8);
    end
    chk("full drop", drop_cnt, 2);
    chk("full valid", evt_valid, 1);

    // Pop on the same edge as a push into a full FIFO: nothing dropped.
    n = cyc; leds(0, 1, 0);
    wait_cyc(n + 6); evt_ready = 1;
    wait_cyc(n + 7); evt_ready = 0;
    chk("simul drop", drop_cnt, 2);
    p0 = pops; evt_ready = 1; tick(8);
    chk("simul occupancy", pops - p0, 4);

    // Asynchronous reset mid-qualification with two events queued.
    evt_ready = 0;
    leds(1, 0, 0); tick(8);
    leds(0, 1, 0); tick(8);
    chk("pre-rst valid", evt_valid, 1);
    leds(0, 0, 1); tick(3);
    #3 rst_n = 0;
    #1;
    chk("async valid", evt_valid, 0);
    chk("async cur", cur_colour, 0);
    chk("async drop", drop_cnt, 0);
    @(negedge clk); rst_n = 1; evt_ready = 1;
    g = 0;
    while (!evt_valid && g < 60) begin @(negedge clk); g++; end
    chk("post-rst seen", evt_valid, 1);
    chk("post-rst seq", evt_seq, 0);
    chk("post-rst colour", evt_colour, 3);

    // Randomised segments against the reference model.
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 2))
          0:       rgb = 3'b100;
          1:       rgb = 3'b010;
          default: rgb = 3'b001;
        endcase
      end else begin
        rgb = 3'($urandom_range(0, 7));
      end
      leds(rgb[2], rgb[1], rgb[0]);
      len = $urandom_range(1, 12);
      pr  = $urandom_range(0, 4);
      for (int c = 0; c < len; c++) begin
        evt_ready = ($urandom_range(0, 3) < pr);
        tick(1);
      end
    end
    evt_ready = 1; tick(30);
    chk("drained", scb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
